// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES signed scores, one per beat.
// Define ARGMAX_TOP2_EN to add runner-up index/value and margin outputs.
module argmax_stream #(
  parameter int DATA_W      = 20,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_val,
  output logic                     count_err
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]         second_idx,
  output logic signed [DATA_W-1:0] second_val,
  output logic [DATA_W:0]          margin
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] k;
  logic             first;
  logic             accept;
  logic             terminal;
  logic             err;
  logic             gt_max;

  logic signed [DATA_W-1:0] upd_val;
  logic [IDX_W-1:0]         upd_idx;

  assign in_ready = rst_n && (state != DONE);
  assign accept   = in_valid && in_ready;
  assign first    = (state == IDLE);
  assign k        = first ? '0 : cnt;
  assign terminal = in_last || (k == LAST_K);
  // short frame (early last) or unmarked frame (no last at final slot)
  assign err      = in_last ^ (k == LAST_K);
  assign gt_max   = in_data > max_val;

  // next running maximum; strict compare keeps the lowest index on ties
  always_comb begin
    upd_val = max_val;
    upd_idx = max_idx;
    if (first) begin
      upd_val = in_data;
      upd_idx = '0;
    end else if (gt_max) begin
      upd_val = in_data;
      upd_idx = k;
    end
  end

`ifdef ARGMAX_TOP2_EN
  localparam logic signed [DATA_W-1:0] MIN_VAL =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] upd_sval;
  logic [IDX_W-1:0]         upd_sidx;

  // runner-up: displaced max, or any beat beating the current second
  always_comb begin
    upd_sval = second_val;
    upd_sidx = second_idx;
    if (first) begin
      upd_sval = MIN_VAL;
      upd_sidx = '0;
    end else if (gt_max) begin
      upd_sval = max_val;
      upd_sidx = max_idx;
    end else if (in_data > second_val) begin
      upd_sval = in_data;
      upd_sidx = k;
    end
  end

  // runner-up registers, updated on every accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_val <= '0;
      second_idx <= '0;
    end else if (accept) begin
      second_val <= upd_sval;
      second_idx <= upd_sidx;
    end
  end

  assign margin = {max_val[DATA_W-1], max_val}
                - {second_val[DATA_W-1], second_val};
`endif

  // frame FSM, beat counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      max_idx   <= '0;
      max_val   <= '0;
      count_err <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            max_val <= upd_val;
            max_idx <= upd_idx;
            if (terminal) begin
              state     <= DONE;
              out_valid <= 1'b1;
              count_err <= err;
              cnt       <= '0;
            end else begin
              state <= ACCUM;
              cnt   <= k + ONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default build plus a 16x8 instance.
// Top-2 checks are compiled in when ARGMAX_TOP2_EN is defined.
module tb_argmax_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  max_idx;
  logic signed [19:0] max_val;
  logic        count_err;
`ifdef ARGMAX_TOP2_EN
  logic [3:0]  second_idx;
  logic signed [19:0] second_val;
  logic [20:0] margin;
`endif

  argmax_stream #(.DATA_W(20), .NUM_CLASSES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_idx(max_idx), .max_val(max_val),
    .count_err(count_err)
`ifdef ARGMAX_TOP2_EN
    , .second_idx(second_idx), .second_val(second_val),
    .margin(margin)
`endif
  );

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = '0;
  logic       b_in_last = 1'b0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [3:0] b_max_idx;
  logic signed [7:0] b_max_val;
  logic       b_count_err;
`ifdef ARGMAX_TOP2_EN
  logic [3:0] b_second_idx;
  logic signed [7:0] b_second_val;
  logic [8:0] b_margin;
`endif

  argmax_stream #(.DATA_W(8), .NUM_CLASSES(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .max_idx(b_max_idx), .max_val(b_max_val),
    .count_err(b_count_err)
`ifdef ARGMAX_TOP2_EN
    , .second_idx(b_second_idx), .second_val(b_second_val),
    .margin(b_margin)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input int d, input bit last, input int gap);
    int b;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = 20'(d);
    in_last  = last;
    b = 0;
    while (!in_ready && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    if (b == 50) check("beat_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input int ei,
                               input int ev, input bit ee);
    check({name, "_latency"}, 64'(out_valid), 64'd1);
    check({name, "_idx"}, 64'(max_idx), 64'(ei));
    check({name, "_val"}, max_val, ev);
    check({name, "_err"}, 64'(count_err), 64'(ee));
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_drop_valid"}, 64'(out_valid), 64'd0);
    check({name, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    int n;
    bit last;
    int gap;
    int exp_idx;
    int exp_val;
    bit exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];
  int   vals [NV][10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string nm;
    vals = '{
      '{3, -7, 12, 5, 0, 12, -1, 4, 9, 2},
      '{-524288, -5, -3, -3, -100, -9, -8, -7, -6, -4},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{5, -2, 8, 0, 0, 0, 0, 0, 0, 0},
      '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 100},
      '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{-524288, -524288, -524288, -524288, -524288,
        -524288, -524288, -524288, -524288, -524288},
      '{524287, 0, 1, 2, 3, 4, 5, 6, 7, 524287}
    };
    tbl[0] = '{10, 1'b1, 0, 2, 12, 1'b0};
    tbl[1] = '{10, 1'b1, 0, 2, -3, 1'b0};
    tbl[2] = '{10, 1'b0, 0, 0, 0, 1'b1};
    tbl[3] = '{3, 1'b1, 1, 2, 8, 1'b1};
    tbl[4] = '{10, 1'b1, 0, 9, 100, 1'b0};
    tbl[5] = '{1, 1'b1, 0, 0, 7, 1'b1};
    tbl[6] = '{10, 1'b1, 0, 0, -524288, 1'b0};
    tbl[7] = '{10, 1'b0, 0, 0, 524287, 1'b1};

    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_max_idx", 64'(max_idx), 64'd0);
    check("rst_max_val", max_val, 64'd0);
    check("rst_count_err", 64'(count_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int v = 0; v < NV; v++) begin
      nm = $sformatf("vec%0d", v);
      for (int i = 0; i < tbl[v].n; i++) begin
        if (i == tbl[v].n - 1 && i > 0)
          check({nm, "_early_valid"}, 64'(out_valid), 64'd0);
        send_beat(vals[v][i], tbl[v].last && (i == tbl[v].n - 1),
                  tbl[v].gap);
      end
      expect_result(nm, tbl[v].exp_idx, tbl[v].exp_val,
                    tbl[v].exp_err);
      release_result(nm);
    end

    for (int i = 0; i < 10; i++) send_beat(vals[0][i], i == 9, 0);
    expect_result("bp", 2, 12, 1'b0);
`ifdef ARGMAX_TOP2_EN
    check("bp_second_idx", 64'(second_idx), 64'd5);
    check("bp_second_val", second_val, 64'd12);
    check("bp_margin", 64'(margin), 64'd0);
`endif
    in_valid = 1'b1;
    in_data  = 20'd1000;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      check("bp_hold_idx", 64'(max_idx), 64'd2);
      check("bp_hold_val", max_val, 64'd12);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result("bp");
    send_beat(-5, 1'b0, 0);
    send_beat(-6, 1'b1, 0);
    expect_result("bp_next", 0, -5, 1'b1);
    release_result("bp_next");

    send_beat(1, 1'b0, 2);
    send_beat(9, 1'b0, 2);
    send_beat(2, 1'b0, 2);
    send_beat(3, 1'b1, 2);
    expect_result("bubble", 1, 9, 1'b1);
    release_result("bubble");

    for (int i = 0; i < 6; i++) send_beat(50 + 10 * i, 1'b0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_max_val", max_val, 64'd0);
    check("mid_rst_max_idx", 64'(max_idx), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_beat(i, i == 9, 0);
    expect_result("after_rst", 9, 9, 1'b0);
    release_result("after_rst");

    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = (i == 15) ? 8'sd127 : 8'(i - 100);
      b_in_last  = (i == 15);
      if (i == 0) check("w16_ready", 64'(b_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    check("w16_valid", 64'(b_out_valid), 64'd1);
    check("w16_idx", 64'(b_max_idx), 64'd15);
    check("w16_val", b_max_val, 64'd127);
    check("w16_err", 64'(b_count_err), 64'd0);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("w16_drop", 64'(b_out_valid), 64'd0);

    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'h80;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    check("w16u_valid", 64'(b_out_valid), 64'd1);
    check("w16u_idx", 64'(b_max_idx), 64'd0);
    check("w16u_val", b_max_val, -64'sd128);
    check("w16u_err", 64'(b_count_err), 64'd1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
